// File: rtl/led_zone_pkg.sv
// Shared types and default dimensions for the LED zone controller.
// Pure definitions; no logic, no latency, no flow control.
package led_zone_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        SET    = 2'd1,
        TOGGLE = 2'd2,
        FLASH  = 2'd3
    } op_t;

    localparam int DEF_ROWS        = 16;
    localparam int DEF_COLS        = 16;
    localparam int DEF_LANES       = 4;
    localparam int DEF_LANE_W      = 4;
    localparam int DEF_ZONES       = 3;
    localparam int DEF_ZONE_H      = 2;
    localparam int DEF_FLASH_TICKS = 8;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_zone_if.sv
// Event request channel into the LED zone controller.
// Combinational ready; one request per cycle, no queueing behind it.
interface led_zone_if
    import led_zone_pkg::*;
#(
    parameter int ZONES = DEF_ZONES,
    parameter int LANES = DEF_LANES
) ();

    localparam int ZW = idx_w(ZONES);
    localparam int LW = idx_w(LANES);

    logic          ev_valid;
    logic          ev_ready;
    logic [ZW-1:0] ev_zone;
    logic [LW-1:0] ev_lane;
    op_t           ev_op;

    modport master (output ev_valid, ev_zone, ev_lane, ev_op, input ev_ready);
    modport slave  (input ev_valid, ev_zone, ev_lane, ev_op, output ev_ready);

endinterface

// File: rtl/led_zone_flash_timer.sv
// Per-region flash countdown: load, cancel, tick-paced decrement, expiry pulse.
// Counter updates on the edge after its inputs; expire is combinational.
// No backpressure; load/cancel win over tick, clear wins over everything.
module flash_timer
    import led_zone_pkg::*;
#(
    parameter int FLASH_TICKS = DEF_FLASH_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic cancel,
    input  logic tick,
    output logic active,
    output logic expire
);

    localparam int CW = $clog2(FLASH_TICKS + 1);

    logic [CW-1:0] cnt;

    assign active = (cnt != '0);
    // Expiry only when nothing else touches the region this cycle.
    assign expire = tick && (cnt == CW'(1)) && !load && !cancel && !clear;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(FLASH_TICKS);
        end else if (cancel) begin
            cnt <= '0;
        end else if (tick && active) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/led_zone_ctrl.sv
// Zone/lane pixel matrix controller with per-region flash timers.
// Event effects and expiries land on the edge after acceptance (latency 1).
// ev_ready drops only during reset or clear_all; otherwise one event per cycle.
module led_zone_ctrl
    import led_zone_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int LANES       = DEF_LANES,
    parameter int LANE_W      = DEF_LANE_W,
    parameter int ZONES       = DEF_ZONES,
    parameter int ZONE_H      = DEF_ZONE_H,
    parameter int FLASH_TICKS = DEF_FLASH_TICKS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        clear_all,
    led_zone_if.slave                   ev,
    output logic [ROWS-1:0][COLS-1:0]   pixels,
    output logic [ZONES*LANES-1:0]      flashing,
    output logic                        err_sticky
);

    localparam int NREG = ZONES * LANES;

    if (LANES * LANE_W > COLS) begin : g_bad_cols
        $error("led_zone_ctrl: LANES*LANE_W exceeds COLS");
    end
    if (ZONES * ZONE_H > ROWS) begin : g_bad_rows
        $error("led_zone_ctrl: ZONES*ZONE_H exceeds ROWS");
    end
    if (FLASH_TICKS < 1 || FLASH_TICKS > 255) begin : g_bad_ticks
        $error("led_zone_ctrl: FLASH_TICKS outside 1..255");
    end

    logic            ev_fire;
    logic            in_range;
    logic [NREG-1:0] hit;
    logic [NREG-1:0] expire;

    assign ev.ev_ready = !reset && !clear_all;
    assign ev_fire     = ev.ev_valid && ev.ev_ready;
    assign in_range    = (int'(ev.ev_zone) < ZONES) && (int'(ev.ev_lane) < LANES);

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam int I = z * LANES + l;

            assign hit[I] = ev_fire && in_range &&
                            (int'(ev.ev_zone) == z) && (int'(ev.ev_lane) == l);

            flash_timer #(
                .FLASH_TICKS (FLASH_TICKS)
            ) u_timer (
                .clk    (clk),
                .reset  (reset),
                .clear  (clear_all),
                .load   (hit[I] && (ev.ev_op == FLASH)),
                .cancel (hit[I] && (ev.ev_op != FLASH)),
                .tick   (tick),
                .active (flashing[I]),
                .expire (expire[I])
            );
        end
    end

    // Lane 0 sits at the high-numbered columns, hence the COLS-(l+1)*LANE_W base.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixels     <= '0;
            err_sticky <= 1'b0;
        end else if (clear_all) begin
            pixels <= '0;
        end else begin
            if (ev_fire && !in_range) begin
                err_sticky <= 1'b1;
            end
            for (int z = 0; z < ZONES; z++) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int r = 0; r < ZONE_H; r++) begin
                        for (int c = 0; c < LANE_W; c++) begin
                            if (hit[z*LANES+l]) begin
                                case (ev.ev_op)
                                    CLEAR:  pixels[z*ZONE_H+r][COLS-(l+1)*LANE_W+c] <= 1'b0;
                                    SET:    pixels[z*ZONE_H+r][COLS-(l+1)*LANE_W+c] <= 1'b1;
                                    TOGGLE: pixels[z*ZONE_H+r][COLS-(l+1)*LANE_W+c] <=
                                                ~pixels[z*ZONE_H+r][COLS-(l+1)*LANE_W+c];
                                    FLASH:  pixels[z*ZONE_H+r][COLS-(l+1)*LANE_W+c] <= 1'b1;
                                endcase
                            end else if (expire[z*LANES+l]) begin
                                pixels[z*ZONE_H+r][COLS-(l+1)*LANE_W+c] <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_zone_ctrl.sv
// Bench for led_zone_ctrl: directed vector table, then random traffic vs a region-level model.
module tb_led_zone_ctrl;
    import led_zone_pkg::*;

    localparam int ROWS = 16, COLS = 16, LANES = 4, LANE_W = 4, ZONES = 3, ZONE_H = 2;
    localparam int FT   = 3;
    localparam int NREG = ZONES * LANES;

    logic                       clk;
    logic                       reset;
    logic                       tick;
    logic                       clear_all;
    logic [ROWS-1:0][COLS-1:0]  pixels;
    logic [NREG-1:0]            flashing;
    logic                       err_sticky;

    led_zone_if #(.ZONES(ZONES), .LANES(LANES)) evif ();

    led_zone_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .LANES(LANES), .LANE_W(LANE_W),
        .ZONES(ZONES), .ZONE_H(ZONE_H), .FLASH_TICKS(FT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .clear_all  (clear_all),
        .ev         (evif),
        .pixels     (pixels),
        .flashing   (flashing),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic got_rdy;

    // Reference model: region-level view of the matrix.
    logic [ROWS-1:0][COLS-1:0] mpix;
    int                        mcnt [NREG];
    logic                      merr;

    task automatic fill_region(input int i, input int mode);
        int zr, lr;
        zr = i / LANES;
        lr = i % LANES;
        for (int r = zr * ZONE_H; r < (zr + 1) * ZONE_H; r++)
            for (int c = COLS - (lr + 1) * LANE_W; c < COLS - lr * LANE_W; c++)
                case (mode)
                    0: mpix[r][c] = 1'b0;
                    1: mpix[r][c] = 1'b1;
                    default: mpix[r][c] = ~mpix[r][c];
                endcase
    endtask

    task automatic model_step(input bit rst, clr, tk, v, input int z, l, input op_t o);
        int hit_i;
        if (rst) begin
            mpix = '0;
            merr = 1'b0;
            foreach (mcnt[i]) mcnt[i] = 0;
        end else if (clr) begin
            mpix = '0;
            foreach (mcnt[i]) mcnt[i] = 0;
        end else begin
            hit_i = -1;
            if (v) begin
                if (z < ZONES && l < LANES) hit_i = z * LANES + l;
                else merr = 1'b1;
            end
            for (int i = 0; i < NREG; i++) begin
                if (i == hit_i) begin
                    case (o)
                        CLEAR:   fill_region(i, 0);
                        TOGGLE:  fill_region(i, 2);
                        default: fill_region(i, 1);
                    endcase
                    mcnt[i] = (o == FLASH) ? FT : 0;
                end else if (tk && mcnt[i] > 0) begin
                    mcnt[i]--;
                    if (mcnt[i] == 0) fill_region(i, 0);
                end
            end
        end
    endtask

    function automatic logic [NREG-1:0] model_flash();
        logic [NREG-1:0] f;
        for (int i = 0; i < NREG; i++) f[i] = (mcnt[i] != 0);
        return f;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input bit rst, clr, tk, v, input int z, l, input op_t o);
        @(negedge clk);
        reset          = rst;
        clear_all      = clr;
        tick           = tk;
        evif.ev_valid  = v;
        evif.ev_zone   = 2'(z);
        evif.ev_lane   = 2'(l);
        evif.ev_op     = o;
        #1 got_rdy = evif.ev_ready;
        @(posedge clk);
        model_step(rst, clr, tk, v, z, l, o);
        #1;
    endtask

    typedef struct {
        bit        rst, clr, tk, v;
        int        z, l;
        op_t       op;
        bit        e_rdy;
        int        e_ones;
        int        pr, pc;
        bit        e_pv;
        logic [11:0] e_flash;
        bit        e_err;
    } vec_t;

    vec_t vecs [22];

    initial begin
        //            rst clr tk  v  z  l  op      rdy ones pr pc pv flash   err
        vecs[0]  = '{1, 0, 0, 0, 0, 0, CLEAR,  0,  0, 0, 0, 0, 12'h000, 0};
        vecs[1]  = '{0, 0, 0, 1, 1, 0, SET,    1,  8, 2,12, 1, 12'h000, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, CLEAR,  1,  8, 3,11, 0, 12'h000, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 3, FLASH,  1, 16, 0, 0, 1, 12'h008, 0};
        vecs[4]  = '{0, 0, 1, 0, 0, 0, CLEAR,  1, 16, 1, 3, 1, 12'h008, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 0, CLEAR,  1, 16, 1, 3, 1, 12'h008, 0};
        vecs[6]  = '{0, 0, 1, 0, 0, 0, CLEAR,  1,  8, 1, 3, 0, 12'h000, 0};
        vecs[7]  = '{0, 0, 0, 1, 1, 2, SET,    1, 16, 2, 4, 1, 12'h000, 0};
        vecs[8]  = '{0, 0, 0, 1, 1, 2, TOGGLE, 1,  8, 3, 7, 0, 12'h000, 0};
        vecs[9]  = '{0, 0, 0, 1, 1, 2, TOGGLE, 1, 16, 2, 5, 1, 12'h000, 0};
        vecs[10] = '{0, 0, 0, 1, 2, 1, FLASH,  1, 24, 4, 8, 1, 12'h200, 0};
        vecs[11] = '{0, 0, 1, 0, 0, 0, CLEAR,  1, 24, 5,11, 1, 12'h200, 0};
        vecs[12] = '{0, 0, 1, 0, 0, 0, CLEAR,  1, 24, 5, 8, 1, 12'h200, 0};
        vecs[13] = '{0, 0, 1, 1, 2, 1, FLASH,  1, 24, 4,11, 1, 12'h200, 0};
        vecs[14] = '{0, 0, 1, 0, 0, 0, CLEAR,  1, 24, 5, 9, 1, 12'h200, 0};
        vecs[15] = '{0, 0, 1, 0, 0, 0, CLEAR,  1, 24, 4, 8, 1, 12'h200, 0};
        vecs[16] = '{0, 0, 1, 0, 0, 0, CLEAR,  1, 16, 4, 8, 0, 12'h000, 0};
        vecs[17] = '{0, 0, 0, 1, 3, 0, SET,    1, 16, 2,12, 1, 12'h000, 1};
        vecs[18] = '{0, 0, 0, 1, 1, 2, CLEAR,  1,  8, 2, 4, 0, 12'h000, 1};
        vecs[19] = '{0, 0, 0, 1, 0, 0, FLASH,  1, 16, 0,12, 1, 12'h001, 1};
        vecs[20] = '{0, 1, 1, 1, 2, 3, SET,    0,  0, 0,12, 0, 12'h000, 1};
        vecs[21] = '{1, 0, 0, 1, 1, 0, SET,    0,  0, 2,12, 0, 12'h000, 0};

        reset = 1'b1; clear_all = 1'b0; tick = 1'b0;
        evif.ev_valid = 1'b0; evif.ev_zone = '0; evif.ev_lane = '0; evif.ev_op = CLEAR;
        mpix = '0; merr = 1'b0;
        foreach (mcnt[i]) mcnt[i] = 0;

        for (int k = 0; k < 22; k++) begin
            apply(vecs[k].rst, vecs[k].clr, vecs[k].tk, vecs[k].v,
                  vecs[k].z, vecs[k].l, vecs[k].op);
            check($sformatf("vec%0d ev_ready", k), 256'(got_rdy), 256'(vecs[k].e_rdy));
            check($sformatf("vec%0d ones", k), 256'($countones(pixels)), 256'(vecs[k].e_ones));
            check($sformatf("vec%0d pixel[%0d][%0d]", k, vecs[k].pr, vecs[k].pc),
                  256'(pixels[vecs[k].pr][vecs[k].pc]), 256'(vecs[k].e_pv));
            check($sformatf("vec%0d flashing", k), 256'(flashing), 256'(vecs[k].e_flash));
            check($sformatf("vec%0d err_sticky", k), 256'(err_sticky), 256'(vecs[k].e_err));
        end

        for (int n = 0; n < 3000; n++) begin
            bit rst, clr, tk, v;
            int z, l;
            op_t o;
            rst = (n == 0) || ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 39) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            v   = $urandom_range(0, 1) == 1;
            z   = $urandom_range(0, 3);
            l   = $urandom_range(0, 3);
            o   = op_t'($urandom_range(0, 3));
            apply(rst, clr, tk, v, z, l, o);
            check("rand ev_ready", 256'(got_rdy), 256'(!rst && !clr));
            check("rand pixels", 256'(pixels), 256'(mpix));
            check("rand flashing", 256'(flashing), 256'(model_flash()));
            check("rand err_sticky", 256'(err_sticky), 256'(merr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_zone_ctrl.md
LED_ZONE_CTRL -- requirements
Module: led_zone_ctrl

Interface
REQ-001 Parameter ROWS, default 16: pixel matrix rows.
REQ-002 Parameter COLS, default 16: pixel matrix columns.
REQ-003 Parameter LANES, default 4: note lanes, each LANE_W columns wide.
REQ-004 Parameter LANE_W, default 4: columns per lane.
REQ-005 Parameter ZONES, default 3: row bands, each ZONE_H rows high.
REQ-006 Parameter ZONE_H, default 2: rows per zone.
REQ-007 Parameter FLASH_TICKS, default 8: flash duration in tick strobes, legal range 1..255.
REQ-008 Ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle frame strobe that paces flash timers.
- clear_all  in  1  blanks the whole matrix and cancels all flashes.
- ev_valid  in  1  event request.
- ev_ready  out  1  event can be accepted this cycle.
- ev_zone  in  $clog2(ZONES)  target zone.
- ev_lane  in  $clog2(LANES)  target lane.
- ev_op  in  2  operation code: CLEAR=0, SET=1, TOGGLE=2, FLASH=3.
- pixels  out  ROWS x COLS  registered pixel matrix, indexed [row][col].
- flashing  out  ZONES*LANES  one bit per region with an active flash; bit index = zone*LANES+lane.
- err_sticky  out  1  an out-of-range event has been dropped.

Function
REQ-009 Region (z,l) SHALL cover rows z*ZONE_H .. z*ZONE_H+ZONE_H-1 and columns COLS-(l+1)*LANE_W .. COLS-l*LANE_W-1, so lane 0 is the highest-numbered columns.
REQ-010 Pixels outside every region SHALL stay 0. They are cleared only by reset or clear_all.
REQ-011 ev_ready SHALL equal !reset && !clear_all. It is combinational.
REQ-012 An event is accepted on a rising edge where ev_valid && ev_ready. Its effect SHALL be visible on pixels and flashing immediately after that same edge (latency 1).
REQ-013 CLEAR SHALL write 0 to every pixel of the region. SET SHALL write 1. TOGGLE SHALL invert each pixel.
REQ-014 CLEAR, SET and TOGGLE SHALL cancel any active flash on that region by zeroing its counter.
REQ-015 FLASH SHALL set the region to all 1s and load its counter with FLASH_TICKS. This also applies when the region is already flashing (the counter reloads).
REQ-016 On each tick, every nonzero counter SHALL decrement by 1. When a counter goes from 1 to 0, the region SHALL be cleared on that same edge.
REQ-017 When an accepted event and a tick or expiry hit the same region in the same cycle, the event wins: no decrement and no expiry clear for that region.
REQ-018 Counter width SHALL be $clog2(FLASH_TICKS+1). Counters SHALL never wrap below 0.
REQ-019 An event with ev_zone >= ZONES or ev_lane >= LANES SHALL be accepted, have no effect on pixels, and set err_sticky to 1. err_sticky is cleared only by reset.
REQ-020 clear_all SHALL zero pixels and all counters on the next edge. It takes precedence over tick.
REQ-021 flashing[i] SHALL be 1 exactly when counter i is nonzero.
REQ-022 The block SHALL accept at most one event per cycle. There is no queueing.

Reset
REQ-023 On reset, pixels, all counters, flashing and err_sticky SHALL become 0.
REQ-024 Reset takes precedence over clear_all, tick and events. An event presented during reset is not accepted, and any flash in progress is aborted.

Structure
REQ-025 Package led_zone_pkg SHALL hold the op_t enum (CLEAR, SET, TOGGLE, FLASH) and the default dimension constants.
REQ-026 Sub-module flash_timer SHALL implement one region counter (load, cancel, tick, expire pulse). It is instantiated ZONES*LANES times via generate.
REQ-027 Elaboration SHALL fail if LANES*LANE_W > COLS, ZONES*ZONE_H > ROWS, or FLASH_TICKS is outside 1..255.

Verification
REQ-028 Case: after reset, SET (z=1,l=0). Required: rows 2-3, cols 12-15 are 1; every other pixel is 0; flashing=0.
REQ-029 Case: FLASH (z=0,l=3) with FLASH_TICKS=3, then 3 ticks. Required: flashing[3] is 1 through ticks 1-2. Rows 0-1, cols 0-3 clear on the edge of tick 3, and flashing[3] drops on that edge.
REQ-030 Case: FLASH (z=2,l=1) after 2 ticks, then FLASH again on the same cycle as a tick. Required: the counter reloads to FLASH_TICKS and is not decremented.
REQ-031 Case: TOGGLE (z=1,l=2) twice on a SET region. Required: after the first edge, rows 2-3, cols 4-7 are 0; after the second, they are 1.
REQ-032 Case: event with ev_zone=3 (ZONES=3). Required: accepted with ev_ready=1, pixels unchanged, err_sticky=1 and held until reset.
REQ-033 Case: clear_all asserted during an active flash and a pending event. Required: ev_ready=0, event not taken; pixels=0 and flashing=0 after the edge.
